// File: rtl/fb_swap_ctrl.sv
// Double-buffered frame-memory controller: renderer writes the back bank, display reads the front.
// Optional sticky framing-error output enabled by defining FB_ERR_EN.
module fb_swap_ctrl #(
    parameter int COLS  = 64,
    parameter int ROWS  = 32,
    parameter int PIX_W = 12,
    localparam int AW   = $clog2(COLS * ROWS / 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             dspl_vsync,
    output logic             mem_we,
    output logic             mem_wbank,
    output logic             mem_whalf,
    output logic [AW-1:0]    mem_waddr,
    output logic [PIX_W-1:0] mem_wdata,
    output logic             rd_bank,
    output logic             swapped
`ifdef FB_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int IW = $clog2(COLS * ROWS);
    localparam logic [IW-1:0] LAST = IW'(COLS * ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PEND
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] wr_idx;
    logic          hs;
    logic          do_wr;
    logic          wr_last;

    // A start-of-frame pixel always lands at raster position 0.
    assign hs        = pix_valid & pix_ready;
    assign wr_idx    = pix_sof ? '0 : idx;
    assign do_wr     = hs & (pix_sof | (state == FILL));
    assign wr_last   = (wr_idx == LAST);
    assign mem_wbank = ~rd_bank;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            pix_ready <= 1'b0;
            mem_we    <= 1'b0;
            mem_whalf <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            rd_bank   <= 1'b0;
            swapped   <= 1'b0;
        end else begin
            mem_we  <= do_wr;
            swapped <= 1'b0;
            if (do_wr) begin
                {mem_whalf, mem_waddr} <= wr_idx;
                mem_wdata              <= pix_data;
            end
            unique case (state)
                IDLE, FILL: begin
                    pix_ready <= 1'b1;
                    if (do_wr) begin
                        if (wr_last) begin
                            state     <= PEND;
                            idx       <= '0;
                            pix_ready <= 1'b0;
                        end else begin
                            state <= FILL;
                            idx   <= wr_idx + 1'b1;
                        end
                    end
                end
                PEND: begin
                    // Renderer is stalled until the display side is idle.
                    pix_ready <= 1'b0;
                    if (dspl_vsync) begin
                        rd_bank   <= ~rd_bank;
                        swapped   <= 1'b1;
                        state     <= IDLE;
                        pix_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pix_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef FB_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (hs & (((state == FILL) & pix_sof) |
                           ((state == IDLE) & ~pix_sof))) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: constant vector table, directed frame sequences,
// and randomized traffic checked against a raster-position reference model.
module tb_fb_swap_ctrl;

    localparam int FRAME = 2048;
    localparam int HALF  = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic [11:0] pix_data;
    logic        dspl_vsync;
    logic        mem_we;
    logic        mem_wbank;
    logic        mem_whalf;
    logic [9:0]  mem_waddr;
    logic [11:0] mem_wdata;
    logic        rd_bank;
    logic        swapped;
`ifdef FB_ERR_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    fb_swap_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_data   (pix_data),
        .dspl_vsync (dspl_vsync),
        .mem_we     (mem_we),
        .mem_wbank  (mem_wbank),
        .mem_whalf  (mem_whalf),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .rd_bank    (rd_bank),
        .swapped    (swapped)
`ifdef FB_ERR_EN
        ,
        .err        (err)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: mode 0 = waiting for sof, 1 = filling, 2 = frame complete
    int m_mode, m_pos, m_ready, m_bank, m_we, m_sw;
    int m_whalf, m_waddr, m_wdata, m_err;
    int n_hs   = 0;
    int dut_wr = 0;
    int dut_top = 0;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_edge(logic r, logic v, logic s,
                                       logic [11:0] d, logic vs);
        int p;
        m_we = 0;
        m_sw = 0;
        if (r) begin
            m_mode = 0; m_pos = 0; m_ready = 0; m_bank = 0;
            m_whalf = 0; m_waddr = 0; m_wdata = 0; m_err = 0;
        end else begin
            if (m_mode == 2) begin
                if (vs) begin
                    m_bank = 1 - m_bank;
                    m_sw   = 1;
                    m_mode = 0;
                end
            end else if (v && m_ready != 0) begin
                n_hs++;
                if (s || m_mode == 1) begin
                    if (s && m_mode == 1) m_err = 1;
                    p       = s ? 0 : m_pos;
                    m_we    = 1;
                    m_whalf = p / HALF;
                    m_waddr = p % HALF;
                    m_wdata = int'(d);
                    m_pos   = p + 1;
                    m_mode  = 1;
                    if (m_pos == FRAME) begin
                        m_mode = 2;
                        m_pos  = 0;
                    end
                end else begin
                    m_err = 1;
                end
            end
            m_ready = (m_mode != 2) ? 1 : 0;
        end
    endfunction

    function automatic void compare_all();
        chk("pix_ready", pix_ready, m_ready);
        chk("mem_we",    mem_we,    m_we);
        chk("mem_wbank", mem_wbank, 1 - m_bank);
        chk("mem_whalf", mem_whalf, m_whalf);
        chk("mem_waddr", mem_waddr, m_waddr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("rd_bank",   rd_bank,   m_bank);
        chk("swapped",   swapped,   m_sw);
`ifdef FB_ERR_EN
        chk("err",       err,       m_err);
`endif
    endfunction

    task automatic cyc(input logic r, input logic v, input logic s,
                       input logic [11:0] d, input logic vs);
        rst        = r;
        pix_valid  = v;
        pix_sof    = s;
        pix_data   = d;
        dspl_vsync = vs;
        @(posedge clk);
        model_edge(r, v, s, d, vs);
        @(negedge clk);
        compare_all();
        if (mem_we) begin
            dut_wr++;
            if (!mem_whalf) dut_top++;
        end
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, i == 0, 12'(i), 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
    endtask

    typedef struct {
        logic        r, v, s;
        logic [11:0] d;
        logic        vs;
        logic        e_ready, e_we, e_sw, e_bank;
        int          e_addr;
        int          e_data;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int wr0, top0, hs0;
        logic v, s, vs;

        rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0;
        pix_data = '0; dspl_vsync = 1'b0;

        //          r  v  s  d       vs rdy we sw bank addr data
        tbl[0] = '{1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 12'h000, 0, 1, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 12'h005, 0, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 1, 1, 12'h123, 0, 1, 1, 0, 0, 0, 'h123};
        tbl[4] = '{0, 1, 0, 12'h456, 0, 1, 1, 0, 0, 1, 'h456};
        tbl[5] = '{0, 0, 0, 12'h000, 1, 1, 0, 0, 0, 1, 'h456};
        tbl[6] = '{0, 1, 0, 12'h007, 0, 1, 1, 0, 0, 2, 'h007};

        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].vs);
            chk("tbl_ready", pix_ready, tbl[i].e_ready);
            chk("tbl_we",    mem_we,    tbl[i].e_we);
            chk("tbl_sw",    swapped,   tbl[i].e_sw);
            chk("tbl_bank",  rd_bank,   tbl[i].e_bank);
            chk("tbl_addr",  mem_waddr, tbl[i].e_addr);
            chk("tbl_data",  mem_wdata, tbl[i].e_data);
        end

        // Full frame into bank 1, then swap after 10 idle cycles
        cyc(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        idle(1);
        wr0 = dut_wr; top0 = dut_top;
        stream(FRAME);
        chk("s1_writes", dut_wr - wr0, FRAME);
        chk("s1_top",    dut_top - top0, HALF);
        idle(10);
        cyc(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
        chk("s1_swapped", swapped, 1);
        chk("s1_rd_bank", rd_bank, 1);
        idle(2);

        // Renderer held valid with no vsync: controller must stall
        stream(FRAME);
        wr0 = dut_wr;
        for (int i = 0; i < 500; i++) cyc(1'b0, 1'b1, 1'b0, 12'hABC, 1'b0);
        chk("s2_no_writes", dut_wr - wr0, 0);
        chk("s2_stalled", pix_ready, 0);
        cyc(1'b0, 1'b1, 1'b0, 12'hABC, 1'b1);
        chk("s2_swapped", swapped, 1);
        chk("s2_ready", pix_ready, 1);
        idle(2);

        // vsync mid-fill is ignored
        for (int i = 0; i < FRAME; i++) begin
            cyc(1'b0, 1'b1, i == 0, 12'(i), i == 700);
        end
        chk("s3_bank_kept", rd_bank, 0);
        idle(3);
        cyc(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
        chk("s3_swap", rd_bank, 1);

        // Restart at idx 300 needs a whole new frame
        stream(300);
        stream(FRAME - 1);
        chk("s4_not_full", pix_ready, 1);
        cyc(1'b0, 1'b1, 1'b0, 12'h7FF, 1'b0);
        chk("s4_full", pix_ready, 0);
`ifdef FB_ERR_EN
        chk("s4_err", err, 1);
`endif
        cyc(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);

        // Reset mid-frame after a swap
        stream(1500);
        cyc(1'b1, 1'b1, 1'b0, 12'h0, 1'b0);
        chk("s5_rd_bank", rd_bank, 0);
        chk("s5_wbank", mem_wbank, 1);
        chk("s5_ready", pix_ready, 0);
        idle(1);
        stream(FRAME);
        cyc(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
        idle(1);

        // Random gaps, vsyncs and occasional restarts
        wr0 = dut_wr; hs0 = n_hs;
        for (int i = 0; i < 14000; i++) begin
            v  = $urandom_range(0, 1) == 1;
            s  = (m_mode == 0) ? 1'b1 : ($urandom_range(0, 999) == 0);
            vs = $urandom_range(0, 99) < 3;
            cyc(1'b0, v, s, 12'($urandom), vs);
        end
        chk("s6_wr_eq_hs", dut_wr - wr0, n_hs - hs0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
